// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scanner
package seg7_pkg;

   localparam int CNT_W = 16;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam seg_t SEG_PAT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_scanner_if.sv
// rtl/seg7_scanner_if.sv - shadow load inputs and multiplexed display outputs
interface seg7_scanner_if
   import seg7_pkg::*;
#(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp;
   logic [DIGITS-1:0]     en;
   logic [DIGITS-1:0]     an;
   seg_t                  seg;
   logic                  dpo;

   modport master (output load, data, dp, en, input an, seg, dpo);
   modport slave  (input load, data, dp, en, output an, seg, dpo);
endinterface

// File: rtl/seg7_scanner_hex_to_seg.sv
// rtl/seg7_scanner_hex_to_seg.sv - combinational hex nibble to active-high segment pattern
module hex_to_seg
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       pattern
);
   assign pattern = SEG_PAT[nibble];
endmodule

// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - time-multiplexed seven-segment driver with guard-blanked digit slots
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int DIV    = 25000,
   parameter int GUARD  = 16,
   parameter int DIGITS = 4
) (
   input  logic           Clock,
   input  logic           Reset,
   seg7_scanner_if.slave  bus
);
   localparam int                SLOT     = (DIV < 2) ? 1 : DIV;
   localparam int                IDX_W    = $clog2(DIGITS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SLOT - 1);
   localparam logic [CNT_W:0]    GUARD_C  = (CNT_W + 1)'(GUARD);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

   if (DIV < 0 || DIV > 65536) begin : g_bad_div
      $error("seg7_scanner: DIV out of range 0..65536");
   end
   if (GUARD < 0 || GUARD >= SLOT) begin : g_bad_guard
      $error("seg7_scanner: GUARD must be below the slot length");
   end
   if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
      $error("seg7_scanner: DIGITS out of range 2..8");
   end

   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] sh_data;
   logic [DIGITS-1:0]   sh_dp;
   logic [DIGITS-1:0]   sh_en;
   logic [3:0]          nib;
   seg_t                pat;
   logic                visible;

   assign nib = sh_data[{idx, 2'b00} +: 4];

   // cnt + 1 > GUARD avoids a constant-true compare when GUARD is 0
   assign visible = (({1'b0, cnt} + 17'd1) > GUARD_C) && sh_en[idx];

   hex_to_seg u_dec (
      .nibble  (nib),
      .pattern (pat)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt     <= '0;
         idx     <= '0;
         sh_data <= '0;
         sh_dp   <= '0;
         sh_en   <= '0;
         bus.an  <= '1;
         bus.seg <= SEG_BLANK;
         bus.dpo <= 1'b1;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // Loading never disturbs the scan position
         if (bus.load) begin
            sh_data <= bus.data;
            sh_dp   <= bus.dp;
            sh_en   <= bus.en;
         end

         if (visible) begin
            bus.an  <= ~(DIGITS'(1) << idx);
            bus.seg <= ~pat;
            bus.dpo <= ~sh_dp[idx];
         end else begin
            bus.an  <= '1;
            bus.seg <= SEG_BLANK;
            bus.dpo <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - randomized and directed checks of seg7_scanner against a time-based model
module tb_seg7_scanner;

   localparam int NI = 4;
   localparam int PDIV [NI] = '{4, 1, 0, 7};
   localparam int PG   [NI] = '{1, 0, 0, 3};
   localparam int PN   [NI] = '{4, 4, 3, 5};

   localparam logic [6:0] HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        load_w [NI];
   logic [31:0] data_w [NI];
   logic [7:0]  dp_w   [NI];
   logic [7:0]  en_w   [NI];
   wire  [7:0]  an_w   [NI];
   wire  [6:0]  seg_w  [NI];
   wire         dpo_w  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      seg7_scanner_if #(.DIGITS(PN[g])) bus ();
      assign bus.load  = load_w[g];
      assign bus.data  = data_w[g][4*PN[g]-1:0];
      assign bus.dp    = dp_w[g][PN[g]-1:0];
      assign bus.en    = en_w[g][PN[g]-1:0];
      assign an_w[g]   = 8'(bus.an);
      assign seg_w[g]  = bus.seg;
      assign dpo_w[g]  = bus.dpo;
      seg7_scanner #(.DIV(PDIV[g]), .GUARD(PG[g]), .DIGITS(PN[g])) u_dut (
         .Clock (clk),
         .Reset (rst),
         .bus   (bus.slave)
      );
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
   endtask

   // Expected {dpo, seg, an} for the edge that follows tt elapsed cycles since reset release
   function automatic logic [15:0] model_out(input int g, input int tt, input logic [31:0] d,
                                             input logic [7:0] p, input logic [7:0] e);
      int slot, c, ix;
      logic [7:0] mask;
      slot = (PDIV[g] < 2) ? 1 : PDIV[g];
      c    = tt % slot;
      ix   = (tt / slot) % PN[g];
      mask = 8'((1 << PN[g]) - 1);
      if (c >= PG[g] && e[ix]) return {~p[ix], ~HEX[d[4*ix +: 4]], mask & ~(8'd1 << ix)};
      return {1'b1, 7'h7F, mask};
   endfunction

   int          t    [NI];
   logic [31:0] msd  [NI];
   logic [7:0]  msdp [NI];
   logic [7:0]  msen [NI];
   logic [15:0] eout [NI];

   always @(posedge clk or posedge rst) begin
      for (int g = 0; g < NI; g++) begin
         if (rst) begin
            t[g]    <= 0;
            msd[g]  <= '0;
            msdp[g] <= '0;
            msen[g] <= '0;
            eout[g] <= {1'b1, 7'h7F, 8'((1 << PN[g]) - 1)};
         end else begin
            eout[g] <= model_out(g, t[g], msd[g], msdp[g], msen[g]);
            t[g]    <= t[g] + 1;
            if (load_w[g]) begin
               msd[g]  <= data_w[g];
               msdp[g] <= dp_w[g];
               msen[g] <= en_w[g];
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         check($sformatf("model_u%0d", g), 32'({dpo_w[g], seg_w[g], an_w[g]}), 32'(eout[g]));
         check($sformatf("onehot_u%0d", g), 32'($countones(an_w[g]) >= PN[g] - 1), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic rand_drive(input int g);
      load_w[g] = ($urandom_range(0, 3) == 0);
      data_w[g] = $urandom;
      dp_w[g]   = 8'($urandom);
      en_w[g]   = 8'($urandom);
   endtask

   task automatic chk_out(input int g, input string name, input logic [7:0] an,
                          input logic [6:0] seg, input logic dpo);
      check(name, 32'({dpo_w[g], seg_w[g], an_w[g]}), 32'({dpo, seg, an}));
   endtask

   task automatic chk_all_off(input string name);
      for (int g = 0; g < NI; g++)
         chk_out(g, $sformatf("%s_u%0d", name, g), 8'((1 << PN[g]) - 1), 7'h7F, 1'b1);
   endtask

   logic [7:0] fast_an [4] = '{8'h0E, 8'h0D, 8'h0B, 8'h07};

   initial begin
      for (int g = 0; g < NI; g++) begin
         load_w[g] = 1'b0;
         data_w[g] = '0;
         dp_w[g]   = '0;
         en_w[g]   = '0;
      end
      repeat (3) @(posedge clk);
      #2;
      load_w[0] = 1'b1; data_w[0] = 32'h3210; dp_w[0] = 8'h04; en_w[0] = 8'h0F;
      load_w[1] = 1'b1; data_w[1] = 32'h3210; dp_w[1] = 8'h00; en_w[1] = 8'h0F;
      rand_drive(2);
      rand_drive(3);
      rst = 1'b0;

      for (int e = 1; e <= 42; e++) begin
         tick();
         if (e == 1 || e == 5)                        chk_out(0, "scan_blank", 8'h0F, 7'h7F, 1'b1);
         if ((e >= 2 && e <= 4) || e == 18 || e == 19) chk_out(0, "scan_d0", 8'h0E, 7'h40, 1'b1);
         if (e >= 6 && e <= 8)                        chk_out(0, "scan_d1", 8'h0D, 7'h79, 1'b1);
         if (e >= 10 && e <= 12)                      chk_out(0, "scan_d2", 8'h0B, 7'h24, 1'b0);
         if (e >= 14 && e <= 16)                      chk_out(0, "scan_d3", 8'h07, 7'h30, 1'b1);
         if (e == 20)                                 chk_out(0, "midload", 8'h0E, 7'h0E, 1'b1);
         if (e >= 25 && e <= 29)                      chk_out(0, "disabled_d2", 8'h0F, 7'h7F, 1'b1);
         if (e == 30)                                 chk_out(0, "d3_after_off", 8'h07, 7'h30, 1'b1);
         if (e >= 2 && e <= 20)                       check("fast_an", 32'(an_w[1]), 32'(fast_an[(e-1)%4]));

         load_w[0] = (e == 18 || e == 21);
         if (e == 18) data_w[0] = 32'h000F;
         if (e == 21) begin
            data_w[0] = 32'h3210;
            en_w[0]   = 8'h0B;
         end
         load_w[1] = 1'b0;
         rand_drive(2);
         rand_drive(3);
      end

      for (int g = 0; g < NI; g++) load_w[g] = 1'b0;
      #1 rst = 1'b1;
      #1 chk_all_off("rst_async");
      tick();
      chk_all_off("rst_hold1");
      tick();
      chk_all_off("rst_hold2");
      rst = 1'b0;
      tick();
      chk_out(0, "post_rst_e1", 8'h0F, 7'h7F, 1'b1);
      tick();
      chk_out(0, "post_rst_e2", 8'h0F, 7'h7F, 1'b1);

      for (int e = 1; e <= 400; e++) begin
         tick();
         if (e == 151) rst = 1'b0;
         for (int g = 0; g < NI; g++) rand_drive(g);
         if (e == 150) #1 rst = 1'b1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Time-multiplexed seven-segment display driver: the output end of the user-interface path, complementing the push-button input conditioning. It holds a shadow copy of the digit values, decimal points and digit enables, loaded atomically on `load`. It cycles through the digits at a prescaled rate and drives active-low anode and segment lines. A guard interval at the start of each digit slot blanks all anodes, which prevents ghosting between adjacent digits.

## Interface
- `DIV`, default 25000: slot length in Clock cycles; values 0 and 1 both mean 1. Legal range is 0..65536.
- `GUARD`, default 16: blank cycles at the start of each slot. It must satisfy GUARD < max(DIV,1); an elaboration-time check rejects other values.
- `DIGITS`, default 4: number of multiplexed digits. Legal range is 2..8.
- `Clock  in  1`: the only clock, rising edge.
- `Reset  in  1`: asynchronous, active-high reset.
- `load  in  1`: when high, capture `data`, `dp` and `en` into the shadow registers.
- `data  in  4*DIGITS`: hex nibble per digit; digit i occupies [4i+3:4i].
- `dp  in  DIGITS`: decimal point per digit, 1 = lit.
- `en  in  DIGITS`: digit enable, 1 = shown, 0 = blank.
- `an  out  DIGITS`: anode selects, active-low, registered.
- `seg  out  7`: segments {g,f,e,d,c,b,a}, active-low, registered.
- `dpo  out  1`: decimal-point segment, active-low, registered.

## Operation
- **State.** The block holds a slot counter `cnt` (16 bits, counts 0..max(DIV,1)-1), a digit index `idx` (0..DIGITS-1) and the shadow registers `sh_data`, `sh_dp`, `sh_en`.
- **Reset values:**
  - `cnt`=0, `idx`=0.
  - All shadow bits 0.
  - `an`=all 1, `seg`=7'h7F, `dpo`=1; all outputs are off.
- **Counter advance, every edge:**
  - If `cnt` == max(DIV,1)-1, then `cnt`←0 and `idx`←(`idx`==DIGITS-1 ? 0 : `idx`+1).
  - Otherwise `cnt`←`cnt`+1.
- **Load.** With `load`=1 at an edge, the shadows take `data`/`dp`/`en` at that edge. Scan state is unaffected; there is no restart of the slot or index. `load` held high reloads on every edge.
- **Output computation.** At every edge the outputs are registered from the pre-edge state (`cnt`, `idx`, shadows):
  - Visible when `cnt` ≥ GUARD and `sh_en[idx]`=1.
  - If visible: `an`=~(1<<`idx`), `seg`=~hexseg(`sh_data` nibble `idx`), `dpo`=~`sh_dp[idx]`.
  - Otherwise: `an`=all 1, `seg`=7'h7F, `dpo`=1.
- **Disabled digits.** A digit with `sh_en`=0 still consumes its full slot, so brightness stays constant regardless of how many digits are enabled.
- **Hex patterns.** The standard patterns for 0–F (active-high before inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **One-hot anodes.** At most one anode is low at any time; this holds for every parameter combination.
- **Reset mid-scan.** Assertion forces all outputs off immediately, asynchronously, and clears the shadows. After release, the scan restarts at digit 0, `cnt`=0.

## Timing
- **Output latency.** Outputs lag the state by one cycle. Load sampled at edge k appears on `seg`/`an` at edge k+1, if the current slot is visible.
- **Frame period.** The frame is DIGITS × max(DIV,1) cycles. Each digit is lit for max(DIV,1)−GUARD cycles per frame.
- **First edges after reset release:**
  - Edge 1: output from `cnt`=0, which is blank whenever GUARD ≥ 1.
  - The first visible edge is edge GUARD+1.
- **DIV ≤ 1.** GUARD must be 0; `idx` advances on every edge and each digit is shown for one cycle.
- **Timing paths.** The scan path has no combinational path from any input to any output.

## Structure
- **Package `seg7_pkg`:**
  - The 16-entry active-high segment pattern constant array.
  - The blank constant 7'h7F.
  - The counter width (16).
- **Sub-module `hex_to_seg`:** combinational nibble-to-pattern decoder, instantiated once and fed by the `idx`-selected shadow nibble.
- **Top level:** counter, index, shadows, output registers and the parameter check.

## Test plan
- **Reset values.** DIV=4, GUARD=1, DIGITS=4. Assert Reset mid-cycle, then check:
  - `an`=4'hF, `seg`=7'h7F, `dpo`=1 immediately, before any Clock edge.
  - Outputs stay so while Reset is held.
- **Scan order.**
  - Stimulus: DIV=4, GUARD=1; load `data`=16'h3210, `en`=4'hF, `dp`=4'b0100.
  - Edges 2–4: `an`=1110, `seg`=7'h40.
  - Edge 5: all off.
  - Edges 6–8: `an`=1101, `seg`=7'h79.
  - Digit 2: `dpo`=0 with `seg`=7'h24.
  - Digit 0 appears again at edges 18–20.
- **Mid-slot load.**
  - Stimulus: while digit 0 shows `0`, pulse `load` with `data`=16'h000F.
  - Next edge: `seg`=7'h0E, with no change in `an` or slot timing.
- **Disabled digit.**
  - Stimulus: `en`=4'b1011.
  - Digit 2's slot keeps `an`=4'hF for all 4 cycles.
  - Digit 3 starts exactly 4 cycles after digit 2's slot began.
- **Reset mid-operation.**
  - Stimulus: assert Reset during digit 2, release, clock 2 edges.
  - Required: digit 0 slot, shadows 0, so `en`=0 and all outputs off until the next load.
- **Fast scan.**
  - Stimulus: DIV=1, GUARD=0, `en`=4'hF.
  - `an` steps 1110→1101→1011→0111→1110 on consecutive edges.
  - Exactly one anode is low on every edge.
